// File: rtl/dr_bank.sv
// JTAG data-register bank: BYPASS, IDCODE, USERCODE and boundary-scan chains,
// with update-stage registers and a negedge-retimed TDO/TDO_EN.
module dr_bank #(
    parameter int unsigned                BSR_LEN        = 8,
    parameter int unsigned                ID_WIDTH       = 8,
    parameter int unsigned                UC_WIDTH       = 8,
    parameter logic [ID_WIDTH-1:0]        IDCODE_VALUE   = 8'hA1,
    parameter logic [UC_WIDTH-1:0]        USERCODE_RESET = 8'h01
) (
    input  logic               TCK,
    input  logic               TRST_N,
    input  logic               TDI,
    input  logic               CAPTUREDR,
    input  logic               SHIFTDR,
    input  logic               UPDATEDR,
    input  logic [2:0]         DR_SEL,
    input  logic [BSR_LEN-1:0] PIN_IN,
    input  logic [BSR_LEN-1:0] CORE_IN,
    output logic [BSR_LEN-1:0] BSR_UPD,
    output logic               BSR_DRIVE,
    output logic [UC_WIDTH-1:0] UR_OUT,
    output logic               TDO,
    output logic               TDO_EN
);

    localparam logic [2:0] SEL_IDCODE   = 3'd1;
    localparam logic [2:0] SEL_SAMPLE   = 3'd2;
    localparam logic [2:0] SEL_EXTEST   = 3'd3;
    localparam logic [2:0] SEL_INTEST   = 3'd4;
    localparam logic [2:0] SEL_USERCODE = 3'd5;

    logic                bypass_q, bypass_d;
    logic [ID_WIDTH-1:0] id_sh_q, id_sh_d;
    logic [UC_WIDTH-1:0] uc_sh_q, uc_sh_d;
    logic [BSR_LEN-1:0]  bsr_sh_q, bsr_sh_d;
    logic [BSR_LEN-1:0]  bsr_upd_q, bsr_upd_d;
    logic [UC_WIDTH-1:0] ur_q, ur_d;
    logic                tdo_q, tdo_d;
    logic                tdo_en_q, tdo_en_d;

    logic sel_id, sel_uc, sel_bsr, sel_bp;
    logic do_cap, do_shift, do_upd;

    always_comb begin
        sel_id  = (DR_SEL == SEL_IDCODE);
        sel_uc  = (DR_SEL == SEL_USERCODE);
        sel_bsr = (DR_SEL == SEL_SAMPLE) || (DR_SEL == SEL_EXTEST) || (DR_SEL == SEL_INTEST);
        sel_bp  = !(sel_id || sel_uc || sel_bsr);

        // Only the highest-priority strobe is allowed to act.
        do_cap   = CAPTUREDR;
        do_shift = SHIFTDR && !CAPTUREDR;
        do_upd   = UPDATEDR && !CAPTUREDR && !SHIFTDR;
    end

    always_comb begin
        bypass_d  = bypass_q;
        id_sh_d   = id_sh_q;
        uc_sh_d   = uc_sh_q;
        bsr_sh_d  = bsr_sh_q;
        bsr_upd_d = bsr_upd_q;
        ur_d      = ur_q;

        if (sel_bp) begin
            if (do_cap)        bypass_d = 1'b0;
            else if (do_shift) bypass_d = TDI;
        end

        if (sel_id) begin
            if (do_cap)        id_sh_d = IDCODE_VALUE;
            else if (do_shift) id_sh_d = {TDI, id_sh_q[ID_WIDTH-1:1]};
        end

        if (sel_uc) begin
            if (do_cap)        uc_sh_d = ur_q;
            else if (do_shift) uc_sh_d = {TDI, uc_sh_q[UC_WIDTH-1:1]};
            else if (do_upd)   ur_d    = uc_sh_q;
        end

        if (sel_bsr) begin
            if (do_cap)        bsr_sh_d  = (DR_SEL == SEL_INTEST) ? CORE_IN : PIN_IN;
            else if (do_shift) bsr_sh_d  = {TDI, bsr_sh_q[BSR_LEN-1:1]};
            else if (do_upd)   bsr_upd_d = bsr_sh_q;
        end
    end

    always_comb begin
        tdo_d    = bypass_q;
        tdo_en_d = SHIFTDR;
        if (sel_id)       tdo_d = id_sh_q[0];
        else if (sel_uc)  tdo_d = uc_sh_q[0];
        else if (sel_bsr) tdo_d = bsr_sh_q[0];
    end

    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            bypass_q  <= 1'b0;
            id_sh_q   <= '0;
            uc_sh_q   <= '0;
            bsr_sh_q  <= '0;
            bsr_upd_q <= '0;
            ur_q      <= USERCODE_RESET;
        end else begin
            bypass_q  <= bypass_d;
            id_sh_q   <= id_sh_d;
            uc_sh_q   <= uc_sh_d;
            bsr_sh_q  <= bsr_sh_d;
            bsr_upd_q <= bsr_upd_d;
            ur_q      <= ur_d;
        end
    end

    // Retiming on the falling edge gives the next device a full half-cycle of setup.
    always_ff @(negedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            tdo_q    <= tdo_d;
            tdo_en_q <= tdo_en_d;
        end
    end

    assign BSR_UPD   = bsr_upd_q;
    assign UR_OUT    = ur_q;
    assign BSR_DRIVE = (DR_SEL == SEL_EXTEST);
    assign TDO       = tdo_q;
    assign TDO_EN    = tdo_en_q;

endmodule
